// File: rtl/keypad_entry.sv
// keypad_entry: decodes 3x4 keypad presses into a decimal entry
// held as BCD and binary, handed downstream over valid/ready.
module keypad_entry #(
   parameter  int DIGITS = 4,
   parameter  int VAL_W  = 14,
   localparam int CNT_W  = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            cursor_x,
   input  logic [3:0]            cursor_y,
   input  logic                  btn_sel,
   output logic [3:0]            hover_key,
   output logic [4*DIGITS-1:0]   bcd_disp,
   output logic [CNT_W-1:0]      digit_cnt,
   output logic                  out_valid,
   output logic [VAL_W-1:0]      out_value,
   input  logic                  out_ready,
   output logic                  err
);

   localparam logic [3:0] KEY_CLR = 4'hA;
   localparam logic [3:0] KEY_ENT = 4'hB;
   localparam logic [3:0] KEY_INV = 4'hF;

   typedef enum logic {
      ST_ENTRY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_sel_d;
   logic [VAL_W-1:0]    r_value;
   logic [VAL_W-1:0]    w_value_nxt;
   logic [4*DIGITS-1:0] r_bcd;
   logic [4*DIGITS-1:0] w_bcd_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [VAL_W-1:0]    r_out_value;
   logic [VAL_W-1:0]    w_out_nxt;
   logic                r_err;
   logic                w_err_nxt;

   logic [3:0]          w_key;
   logic                w_press;
   logic                w_is_digit;
   logic                w_is_clr;
   logic                w_is_ent;
   logic                w_full;
   logic                w_lead_zero;
   logic [VAL_W-1:0]    w_value_acc;

   // Key under the cursor; anything off the 3x4 grid is invalid.
   always_comb begin
      w_key = KEY_INV;
      if (cursor_x < 4'd3 && cursor_y < 4'd4) begin
         unique case (cursor_y[1:0])
            2'd0: w_key = 4'd1 + cursor_x;
            2'd1: w_key = 4'd4 + cursor_x;
            2'd2: w_key = 4'd7 + cursor_x;
            2'd3: begin
               unique case (cursor_x[1:0])
                  2'd0:    w_key = KEY_CLR;
                  2'd1:    w_key = 4'd0;
                  default: w_key = KEY_ENT;
               endcase
            end
         endcase
      end
   end

   assign w_press     = ~btn_sel & r_sel_d;
   assign w_is_digit  = (w_key <= 4'd9);
   assign w_is_clr    = (w_key == KEY_CLR);
   assign w_is_ent    = (w_key == KEY_ENT);
   assign w_full      = (r_cnt == CNT_W'(DIGITS));
   assign w_lead_zero = (w_key == 4'd0) && (r_cnt == '0);

   // Truncating value*10+d to VAL_W bits gives the same result as a
   // wider product; the parameter rule keeps it from overflowing.
   assign w_value_acc = r_value * VAL_W'(10) + VAL_W'(w_key);

   // Next-state and entry-register update for each press / transfer.
   always_comb begin
      w_state_nxt = r_state;
      w_value_nxt = r_value;
      w_bcd_nxt   = r_bcd;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out_value;
      w_err_nxt   = 1'b0;
      unique case (r_state)
         ST_ENTRY: begin
            if (w_press) begin
               unique case (1'b1)
                  w_is_digit: begin
                     if (w_full) begin
                        w_err_nxt = 1'b1;
                     end else if (!w_lead_zero) begin
                        w_value_nxt = w_value_acc;
                        w_bcd_nxt   = {r_bcd[4*DIGITS-5:0], w_key};
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                     end
                  end
                  w_is_clr: begin
                     w_value_nxt = '0;
                     w_bcd_nxt   = '0;
                     w_cnt_nxt   = '0;
                  end
                  w_is_ent: begin
                     w_out_nxt   = r_value;
                     w_state_nxt = ST_HOLD;
                  end
                  default: w_err_nxt = 1'b1;
               endcase
            end
         end
         ST_HOLD: begin
            if (w_press) begin
               w_err_nxt = 1'b1;
            end
            if (out_ready) begin
               w_state_nxt = ST_ENTRY;
               w_value_nxt = '0;
               w_bcd_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = ST_ENTRY;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ENTRY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Entry, output and press-edge registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_d     <= 1'b1;
         r_value     <= '0;
         r_bcd       <= '0;
         r_cnt       <= '0;
         r_out_value <= '0;
         r_err       <= 1'b0;
      end else begin
         r_sel_d     <= btn_sel;
         r_value     <= w_value_nxt;
         r_bcd       <= w_bcd_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_value <= w_out_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign hover_key = w_key;
   assign bcd_disp  = r_bcd;
   assign digit_cnt = r_cnt;
   assign out_valid = (r_state == ST_HOLD);
   assign out_value = r_out_value;
   assign err       = r_err;

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed and random presses checked against
// an integer-level model of the keypad entry.
module tb_keypad_entry;

   localparam int DIGITS = 4;
   localparam int VAL_W  = 14;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cursor_x = 4'd0;
   logic [3:0]  cursor_y = 4'd0;
   logic        btn_sel = 1'b1;
   logic        out_ready = 1'b0;
   logic [3:0]  hover_key;
   logic [15:0] bcd_disp;
   logic [2:0]  digit_cnt;
   logic        out_valid;
   logic [13:0] out_value;
   logic        err;

   keypad_entry #(.DIGITS(DIGITS), .VAL_W(VAL_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .btn_sel(btn_sel), .hover_key(hover_key),
      .bcd_disp(bcd_disp), .digit_cnt(digit_cnt),
      .out_valid(out_valid), .out_value(out_value),
      .out_ready(out_ready), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model: the entry is just an integer; digits and BCD derive from it
   bit m_sel_d = 1'b1;
   bit m_hold  = 1'b0;
   int m_val   = 0;
   int m_out   = 0;
   bit m_err   = 1'b0;

   task automatic check(string tag, int obs, int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int mkey(int x, int y);
      if (x > 2 || y > 3) return 15;
      if (y < 3) return y * 3 + x + 1;
      if (x == 0) return 10;
      if (x == 1) return 0;
      return 11;
   endfunction

   function automatic int ndig(int v);
      int n = 0;
      while (v > 0) begin
         n++;
         v = v / 10;
      end
      return n;
   endfunction

   function automatic int to_bcd(int v);
      int r = 0;
      for (int i = 0; i < DIGITS; i++) begin
         r = r | ((v % 10) << (4 * i));
         v = v / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_sel_d = 1'b1;
      m_hold  = 1'b0;
      m_val   = 0;
      m_out   = 0;
      m_err   = 1'b0;
   endtask

   task automatic check_all(string tag);
      check({tag, ".valid"}, out_valid, m_hold);
      check({tag, ".cnt"}, digit_cnt, ndig(m_val));
      check({tag, ".bcd"}, bcd_disp, to_bcd(m_val));
      check({tag, ".err"}, err, m_err);
      check({tag, ".oval"}, out_value, m_out);
      check({tag, ".hover"}, hover_key,
            mkey(int'(cursor_x), int'(cursor_y)));
   endtask

   // one clock: predict from the inputs, clock, then compare
   task automatic tick(string tag);
      bit press, xfer, nh, ne;
      int key, nv, no;
      press = !btn_sel && m_sel_d;
      xfer  = m_hold && out_ready;
      key   = mkey(int'(cursor_x), int'(cursor_y));
      nv = m_val;
      no = m_out;
      nh = m_hold;
      ne = 1'b0;
      if (press) begin
         if (m_hold) ne = 1'b1;
         else if (key <= 9) begin
            if (ndig(m_val) == DIGITS) ne = 1'b1;
            else nv = m_val * 10 + key;
         end else if (key == 10) nv = 0;
         else if (key == 11) begin
            no = m_val;
            nh = 1'b1;
         end else ne = 1'b1;
      end
      if (xfer) begin
         nh = 1'b0;
         nv = 0;
      end
      @(posedge clk);
      #1;
      m_val   = nv;
      m_out   = no;
      m_hold  = nh;
      m_err   = ne;
      m_sel_d = btn_sel;
      check_all(tag);
   endtask

   task automatic set_cur(int x, int y);
      cursor_x = 4'(x);
      cursor_y = 4'(y);
   endtask

   task automatic cur_digit(int d);
      if (d == 0) set_cur(1, 3);
      else set_cur((d - 1) % 3, (d - 1) / 3);
   endtask

   task automatic press(string tag);
      btn_sel = 1'b0;
      tick(tag);
      btn_sel = 1'b1;
      tick(tag);
   endtask

   task automatic press_digit(int d);
      cur_digit(d);
      press("dig");
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      set_cur(1, 1);
      #1;
      check("rst.valid", out_valid, 0);
      check("rst.cnt", digit_cnt, 0);
      check("rst.bcd", bcd_disp, 0);
      check("rst.err", err, 0);
      check("rst.hover5", hover_key, 5);
      tick("idle");

      // 1 2 3 ENT with ready already high
      out_ready = 1'b1;
      press_digit(1);
      press_digit(2);
      press_digit(3);
      check("t2.bcd", bcd_disp, 16'h0123);
      set_cur(2, 3);
      btn_sel = 1'b0;
      tick("t2.ent");
      check("t2.v1", out_valid, 1);
      check("t2.val", out_value, 123);
      btn_sel = 1'b1;
      tick("t2.x");
      check("t2.v0", out_valid, 0);
      check("t2.cnt0", digit_cnt, 0);
      out_ready = 1'b0;

      // leading zeros, then fill and overflow
      press_digit(0);
      press_digit(0);
      press_digit(7);
      check("t3.cnt", digit_cnt, 1);
      check("t3.bcd7", bcd_disp, 16'h0007);
      press_digit(9);
      press_digit(9);
      press_digit(9);
      cur_digit(4);
      btn_sel = 1'b0;
      tick("t3.ovf");
      check("t3.err", err, 1);
      check("t3.bcd", bcd_disp, 16'h7999);
      btn_sel = 1'b1;
      tick("t3.rel");
      check("t3.err0", err, 0);
      set_cur(0, 3);
      press("clr");

      // backpressure
      press_digit(4);
      press_digit(2);
      set_cur(2, 3);
      press("t4.ent");
      repeat (5) tick("t4.wait");
      check("t4.valid", out_valid, 1);
      check("t4.val", out_value, 42);
      cur_digit(5);
      btn_sel = 1'b0;
      tick("t4.hp");
      check("t4.herr", err, 1);
      check("t4.hbcd", bcd_disp, 16'h0042);
      btn_sel = 1'b1;
      tick("t4.hr");
      out_ready = 1'b1;
      tick("t4.xfer");
      check("t4.v0", out_valid, 0);
      tick("t4.after");
      check("t4.once", out_valid, 0);
      check("t4.keep", out_value, 42);
      out_ready = 1'b0;

      // CLR and invalid key
      press_digit(8);
      press_digit(6);
      set_cur(0, 3);
      btn_sel = 1'b0;
      tick("t5.clr");
      check("t5.cnt", digit_cnt, 0);
      check("t5.err", err, 0);
      btn_sel = 1'b1;
      tick("t5.rel");
      set_cur(3, 0);
      #1 check("t5.hovF", hover_key, 15);
      btn_sel = 1'b0;
      tick("t5.inv");
      check("t5.ierr", err, 1);
      btn_sel = 1'b1;
      tick("t5.irel");

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 9) == 0)
               set_cur($urandom_range(0, 15), $urandom_range(0, 15));
            else
               set_cur($urandom_range(0, 3), $urandom_range(0, 3));
         end
         btn_sel   = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) == 0);
         tick("rnd");
      end
      btn_sel   = 1'b1;
      out_ready = 1'b1;
      tick("drain");
      tick("drain");
      out_ready = 1'b0;
      set_cur(0, 3);
      press("clr2");

      // async reset while holding a value
      press_digit(5);
      set_cur(2, 3);
      press("t6.ent");
      check("t6.hold", out_valid, 1);
      #3 rst_n = 1'b0;
      #1 check("t6.async", out_valid, 0);
      model_reset();
      @(posedge clk);
      #1 check("t6.inrst", out_valid, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick("t6.post");
      check("t6.stay", out_valid, 0);
      check("t6.oval", out_value, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Consumes the 3x4 keypad cursor position (x 0..2, y 0..3) and an active-low select button, and decodes the key under the cursor on each press. Digit keys build a decimal entry of up to DIGITS digits, held as both BCD (for the display) and binary. CLR discards the entry. ENT hands the binary value downstream over a valid/ready handshake. The block sits between the cursor controller and the POS/calculator core.

## Interface
- DIGITS, 4, maximum number of entry digits.
- VAL_W, 14, binary value width; must satisfy 2^VAL_W > 10^DIGITS - 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cursor_x  in  4  cursor column, valid range 0..2.
- cursor_y  in  4  cursor row, valid range 0..3.
- btn_sel  in  1  select button, active-low, already debounced.
- hover_key  out  4  combinational key code under the cursor.
- bcd_disp  out  4*DIGITS  entry digits as BCD; the least-significant digit is in [3:0].
- digit_cnt  out  $clog2(DIGITS+1)  number of digits entered.
- out_valid  out  1  entered value is available.
- out_value  out  VAL_W  binary value; stable while out_valid=1.
- out_ready  in  1  downstream accepts out_value.
- err  out  1  one-cycle pulse when a press is rejected.

## Operation
- Key map, by row (y) then column (x), giving the key code:
  - y0: 1, 2, 3
  - y1: 4, 5, 6
  - y2: 7, 8, 9
  - y3: CLR=4'hA, 0, ENT=4'hB
  - Out-of-range cursor (x>2 or y>3): 4'hF (invalid).
- Press detection:
  - sel_d is a register holding the previous btn_sel; it resets to 1.
  - press = ~btn_sel & sel_d, giving one pulse per press.
  - The key acted on is hover_key in the press cycle.
- States:
  - ENTRY: accepts keys.
  - HOLD: out_valid=1, waiting for out_ready.
- Press handling in ENTRY:
  - Digit d, digit_cnt<DIGITS: value <= value*10 + d, computed at VAL_W+4 bits and truncated to VAL_W (never overflows under the parameter rule). bcd_disp <= {bcd_disp[4*DIGITS-5:0], d}. digit_cnt++.
  - Digit d=0 with digit_cnt=0: accepted with no change (no leading zeros), no err.
  - Digit with digit_cnt=DIGITS: ignored, err pulse.
  - CLR: value, bcd_disp and digit_cnt cleared to 0, no err.
  - ENT: out_value <= value, go to HOLD. An empty entry sends 0.
  - Invalid key: ignored, err pulse.
- Press handling in HOLD:
  - Any press is ignored with an err pulse, including CLR (no retraction of a valid).
  - The entry registers are unchanged.
- Handshake:
  - A transfer occurs on a rising edge with out_valid & out_ready.
  - On transfer: go to ENTRY, and value, bcd_disp and digit_cnt clear to 0.
  - out_value holds its last value until the next ENT.
- Reset values:
  - State ENTRY.
  - out_valid, out_value, bcd_disp, digit_cnt and err all 0.
  - sel_d = 1.
- Reset mid-HOLD abandons the pending value with no transfer.

## Timing
- A press sampled at edge N updates bcd_disp, digit_cnt and err at N+1.
- ENT sampled at edge N: out_valid=1 from N+1.
- out_ready high at edge N+1: out_valid=0 from N+2, so the minimum valid width is 1 cycle.
- out_ready is only meaningful while out_valid=1 and is ignored otherwise.
- A press at the same edge as a transfer is still handled as a HOLD press (rejected, err).
- err is high for exactly one cycle per rejected press.
- Holding btn_sel low produces only one press; release and re-press are needed.
- Cursor changes take effect on hover_key in the same cycle (combinational).

## Test plan
- Reset state: after reset, check out_valid=0, digit_cnt=0, bcd_disp=0, err=0. Cursor (1,1) gives hover_key=5.
- Digit entry and transfer, DIGITS=4: press 1, 2, 3, ENT with out_ready=1 -> bcd_disp=16'h0123, out_value=123, out_valid high 1 cycle, then digit_cnt=0.
- Leading zero and overflow: press 0, 0, 7 -> digit_cnt=1, value 7. Then press 9, 9, 9, 4 -> the fourth of these presses (digit 4) rejects with err and bcd_disp=16'h7999.
- Backpressure: press 4, 2, ENT with out_ready=0 for 5 cycles -> out_valid held and out_value=42 stable. Press 5 during HOLD -> err, no change. Raise out_ready -> one transfer.
- CLR and invalid key: enter 8, 6, then CLR -> all cleared with no err. Cursor (3,0) plus press -> err, hover_key=4'hF.
- Async reset asserted in HOLD -> out_valid drops immediately and stays 0 after release.
